// File: rtl/rect_pixel_writer_pkg.sv
// Shared display definitions: screen geometry, index/colour widths and the fill
// state encoding, plus index/coordinate helpers reused by other display blocks.
package rect_pixel_writer_pkg;

    localparam int SCR_W_DEF = 96;
    localparam int SCR_H_DEF = 64;
    localparam int COORD_W   = 7;
    localparam int IDX_W     = 13;
    localparam int COLOUR_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } fill_state_e;

    // y * k as a sum of shifted copies of y, one per set bit of the constant k,
    // so a fixed screen width never needs a general multiplier.
    function automatic logic [IDX_W-1:0] mul_const(input logic [COORD_W-1:0] y,
                                                   input int k);
        logic [IDX_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < IDX_W; i++) begin
            if (k[i]) begin
                acc = acc + (IDX_W'(y) << i);
            end
        end
        return acc;
    endfunction

    function automatic logic [IDX_W-1:0] xy_to_idx(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input int scr_w);
        return mul_const(y, scr_w) + IDX_W'(x);
    endfunction

    function automatic logic [COORD_W-1:0] idx_to_x(input logic [IDX_W-1:0] idx,
                                                    input int scr_w);
        return COORD_W'(32'(idx) % scr_w);
    endfunction

    function automatic logic [COORD_W-1:0] idx_to_y(input logic [IDX_W-1:0] idx,
                                                    input int scr_w);
        return COORD_W'(32'(idx) / scr_w);
    endfunction

endpackage

// File: rtl/rect_pixel_writer_clip_calc.sv
// Setup arithmetic for a rectangle fill: screen clipping, start index, row step
// and the empty-request test. Purely combinational.
module rect_pixel_writer_clip_calc
    import rect_pixel_writer_pkg::*;
#(
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF
) (
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    output logic [COORD_W-1:0] x_last,
    output logic [COORD_W-1:0] y_last,
    output logic [IDX_W-1:0]   base_idx,
    output logic [IDX_W-1:0]   row_step,
    output logic               empty
);

    localparam logic [COORD_W:0] SCR_W_EXT = (COORD_W+1)'(SCR_W);
    localparam logic [COORD_W:0] SCR_H_EXT = (COORD_W+1)'(SCR_H);
    localparam logic [COORD_W:0] ONE_EXT   = (COORD_W+1)'(1);

    logic [COORD_W:0] x_sum;
    logic [COORD_W:0] y_sum;
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    always_comb begin
        // One extra bit keeps x0+w from wrapping before it is clipped.
        x_sum = {1'b0, x0} + {1'b0, w};
        y_sum = {1'b0, y0} + {1'b0, h};
        x_end = (x_sum > SCR_W_EXT) ? SCR_W_EXT : x_sum;
        y_end = (y_sum > SCR_H_EXT) ? SCR_H_EXT : y_sum;

        x_last = COORD_W'(x_end - ONE_EXT);
        y_last = COORD_W'(y_end - ONE_EXT);

        empty = (w == '0) || (h == '0) ||
                ({1'b0, x0} >= SCR_W_EXT) || ({1'b0, y0} >= SCR_H_EXT);

        base_idx = xy_to_idx(x0, y0, SCR_W);
        // From the last pixel of a row (x_end-1) back to x0 on the next row.
        row_step = IDX_W'(SCR_W) - IDX_W'(x_end) + IDX_W'(x0) + IDX_W'(1);
    end

endmodule

// File: rtl/rect_pixel_writer.sv
// Solid rectangle fill engine: clips a request to the screen and streams one
// framebuffer write per pixel, row-major, over a valid/ready write port.
module rect_pixel_writer
    import rect_pixel_writer_pkg::*;
#(
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF
) (
    input  logic                my_clock,
    input  logic                rst_n,
    input  logic                start,
    input  logic [COORD_W-1:0]  x0,
    input  logic [COORD_W-1:0]  y0,
    input  logic [COORD_W-1:0]  w,
    input  logic [COORD_W-1:0]  h,
    input  logic [COLOUR_W-1:0] colour,
    output logic                busy,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [IDX_W-1:0]    wr_addr,
    output logic [COLOUR_W-1:0] wr_data,
    output logic                done
);

    fill_state_e         state_q, state_d;
    logic [COORD_W-1:0]  x0_q, x0_d;
    logic [COORD_W-1:0]  y0_q, y0_d;
    logic [COORD_W-1:0]  w_q, w_d;
    logic [COORD_W-1:0]  h_q, h_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [COORD_W-1:0]  x_q, x_d;
    logic [COORD_W-1:0]  y_q, y_d;
    logic [COORD_W-1:0]  x_last_q, x_last_d;
    logic [COORD_W-1:0]  y_last_q, y_last_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic [IDX_W-1:0]    row_step_q, row_step_d;

    logic [COORD_W-1:0]  clip_x_last;
    logic [COORD_W-1:0]  clip_y_last;
    logic [IDX_W-1:0]    clip_base_idx;
    logic [IDX_W-1:0]    clip_row_step;
    logic                clip_empty;

    rect_pixel_writer_clip_calc #(
        .SCR_W (SCR_W),
        .SCR_H (SCR_H)
    ) u_clip_calc (
        .x0       (x0_q),
        .y0       (y0_q),
        .w        (w_q),
        .h        (h_q),
        .x_last   (clip_x_last),
        .y_last   (clip_y_last),
        .base_idx (clip_base_idx),
        .row_step (clip_row_step),
        .empty    (clip_empty)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch of the case can infer a latch.
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        colour_d   = colour_q;
        x_d        = x_q;
        y_d        = y_q;
        x_last_d   = x_last_q;
        y_last_d   = y_last_q;
        addr_d     = addr_q;
        row_step_d = row_step_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d     = x0;
                    y0_d     = y0;
                    w_d      = w;
                    h_d      = h;
                    colour_d = colour;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                x_last_d   = clip_x_last;
                y_last_d   = clip_y_last;
                row_step_d = clip_row_step;
                addr_d     = clip_base_idx;
                x_d        = x0_q;
                y_d        = y0_q;
                state_d    = clip_empty ? FINISH : DRAW;
            end
            DRAW: begin
                // The beat only advances once the framebuffer has taken it.
                if (wr_ready) begin
                    if (x_q == x_last_q) begin
                        if (y_q == y_last_q) begin
                            state_d = FINISH;
                        end else begin
                            x_d    = x0_q;
                            y_d    = y_q + COORD_W'(1);
                            addr_d = addr_q + row_step_q;
                        end
                    end else begin
                        x_d    = x_q + COORD_W'(1);
                        addr_d = addr_q + IDX_W'(1);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge my_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            colour_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            x_last_q   <= '0;
            y_last_q   <= '0;
            addr_q     <= '0;
            row_step_q <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            colour_q   <= colour_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x_last_q   <= x_last_d;
            y_last_q   <= y_last_d;
            addr_q     <= addr_d;
            row_step_q <= row_step_d;
        end
    end

    // Outputs decode straight from the state register so reset clears them at once.
    assign busy     = (state_q == SETUP) || (state_q == DRAW);
    assign wr_valid = (state_q == DRAW);
    assign done     = (state_q == FINISH);
    assign wr_addr  = addr_q;
    assign wr_data  = colour_q;

endmodule

// File: tb/tb_rect_pixel_writer.sv
// Directed bench for rect_pixel_writer: a reference model fills a scoreboard of
// expected write beats, and a monitor checks every accepted beat against it.
module tb_rect_pixel_writer;

    localparam int SW = 96;
    localparam int SH = 64;

    logic        my_clock = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [6:0]  x0 = '0, y0 = '0, w = '0, h = '0;
    logic [15:0] colour   = '0;
    logic        wr_ready = 1'b0;
    logic        busy, wr_valid, done;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;

    rect_pixel_writer dut (
        .my_clock (my_clock),
        .rst_n    (rst_n),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .w        (w),
        .h        (h),
        .colour   (colour),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done)
    );

    always #5 my_clock = ~my_clock;

    typedef struct {
        int addr;
        int data;
    } beat_t;

    beat_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc, first_beat_cyc, last_beat_cyc, done_cyc;
    int beats, stalls, done_cnt, done_base;
    logic        stall_pending = 1'b0;
    logic        prev_done     = 1'b0;
    logic [12:0] stall_addr;
    logic [15:0] stall_data;

    always @(posedge my_clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, half a cycle away from DUT updates.
    always @(negedge my_clock) begin
        if (rst_n) begin
            if (stall_pending) begin
                check("stall_valid_held", wr_valid, 1);
                check("stall_addr_held", wr_addr, stall_addr);
                check("stall_data_held", wr_data, stall_data);
            end
            if (wr_valid) begin
                check("addr_in_range", (wr_addr <= 13'd6143), 1);
                if (wr_ready) begin
                    beats++;
                    if (first_beat_cyc < 0) first_beat_cyc = cyc;
                    last_beat_cyc = cyc;
                    stall_pending = 1'b0;
                    check("beat_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("beat_addr", wr_addr, e.addr);
                        check("beat_data", wr_data, e.data);
                    end
                end else begin
                    stall_pending = 1'b1;
                    stall_addr    = wr_addr;
                    stall_data    = wr_data;
                    stalls++;
                end
            end else begin
                stall_pending = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_busy_low", busy, 0);
                check("done_valid_low", wr_valid, 0);
                check("done_single_cycle", prev_done, 0);
            end
            prev_done = done;
        end else begin
            stall_pending = 1'b0;
            prev_done     = 1'b0;
        end
    end

    // Call at posedge+1; start is sampled on the next rising edge.
    task automatic start_rect(input int x, input int y, input int ww, input int hh, input int col);
        int xe, ye;
        x0     = 7'(x);
        y0     = 7'(y);
        w      = 7'(ww);
        h      = 7'(hh);
        colour = 16'(col);
        start  = 1'b1;
        start_cyc      = cyc;
        beats          = 0;
        stalls         = 0;
        first_beat_cyc = -1;
        last_beat_cyc  = -1;
        done_base      = done_cnt;
        xe = (x + ww > SW) ? SW : x + ww;
        ye = (y + hh > SH) ? SH : y + hh;
        for (int yy = y; yy < ye; yy++) begin
            for (int xx = x; xx < xe; xx++) begin
                exp_q.push_back('{yy * SW + xx, col});
            end
        end
        @(posedge my_clock);
        #1;
        start = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic wait_done(input int mode);
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge my_clock);
            #1;
            case (mode)
                1:       wr_ready = pat[3 - (k % 4)];
                2:       wr_ready = 1'($urandom_range(0, 1));
                default: wr_ready = 1'b1;
            endcase
            k++;
            @(negedge my_clock);
            if (done_cnt != done_base) break;
        end
        check("done_count", done_cnt - done_base, 1);
    endtask

    task automatic step();
        @(posedge my_clock);
        #1;
    endtask

    initial begin
        int beats_at_reset;

        // Reset values, before any clock edge.
        #2;
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_done", done, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);

        // Release reset and request in the same cycle: first edge must take it.
        repeat (3) @(posedge my_clock);
        #1;
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        start_rect(10, 5, 3, 2, 16'hF800);
        wait_done(0);
        check("basic_first_latency", first_beat_cyc - start_cyc, 2);
        check("basic_beats", beats, 6);
        check("basic_consecutive", last_beat_cyc - first_beat_cyc, 5);
        check("basic_done_after_last", done_cyc - last_beat_cyc, 1);
        check("basic_queue_empty", exp_q.size(), 0);

        // Start in the cycle right after done.
        step();
        start_rect(0, 1, 2, 1, 16'h07E0);
        wait_done(0);
        check("b2b_first_latency", first_beat_cyc - start_cyc, 2);
        check("b2b_beats", beats, 2);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Bottom-right corner clip to 2x2.
        step();
        start_rect(94, 62, 5, 5, 16'h001F);
        wait_done(0);
        check("clip_beats", beats, 4);
        check("clip_queue_empty", exp_q.size(), 0);

        // Empty requests: zero width, x off screen, y off screen.
        step();
        start_rect(10, 10, 0, 5, 16'h1111);
        wait_done(0);
        check("w0_done_latency", done_cyc - start_cyc, 2);
        check("w0_beats", beats, 0);
        step();
        start_rect(100, 3, 4, 4, 16'h2222);
        wait_done(0);
        check("xoff_done_latency", done_cyc - start_cyc, 2);
        check("xoff_beats", beats, 0);
        step();
        start_rect(5, 70, 3, 3, 16'h3333);
        wait_done(0);
        check("yoff_beats", beats, 0);

        // Backpressure pattern 1,0,0,1.
        step();
        start_rect(0, 0, 4, 1, 16'hAAAA);
        wait_done(1);
        check("stall_beats", beats, 4);
        check("stall_count", stalls, 4);
        check("stall_queue_empty", exp_q.size(), 0);

        // Random backpressure across row wraps.
        step();
        start_rect(40, 20, 5, 3, 16'h1234);
        wait_done(2);
        check("rand_beats", beats, 15);
        check("rand_queue_empty", exp_q.size(), 0);

        // Start pulses while busy must be ignored.
        step();
        wr_ready = 1'b1;
        start_rect(30, 30, 4, 2, 16'h5A5A);
        step();
        x0 = 7'd0; y0 = 7'd0; w = 7'd9; h = 7'd9; colour = 16'hFFFF;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        wait_done(0);
        check("busy_ign_beats", beats, 8);
        repeat (6) step();
        @(negedge my_clock);
        check("busy_ign_no_extra", beats, 8);
        check("busy_ign_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a 10x10 fill.
        step();
        start_rect(0, 0, 10, 10, 16'hC0DE);
        repeat (20) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_wr_valid", wr_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        exp_q.delete();
        beats_at_reset = beats;
        repeat (2) @(posedge my_clock);
        #1;
        rst_n = 1'b1;
        repeat (5) step();
        @(negedge my_clock);
        check("midrst_no_resume", beats, beats_at_reset);
        check("midrst_no_done", done_cnt, done_base);
        step();
        start_rect(20, 10, 2, 2, 16'hBEEF);
        wait_done(0);
        check("postrst_first_latency", first_beat_cyc - start_cyc, 2);
        check("postrst_beats", beats, 4);
        check("postrst_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
